systolic_skew_feeder: RTL and testbench
=======================================

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 SHALL have parameter N, default 4, meaning array dimension and lane count; legal range 2..16.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port array_en  input  1  array advance enable; low freezes the feeder.
REQ-005 SHALL have port in_valid  input  1  input vector valid.
REQ-006 SHALL have port in_ready  output  1  feeder accepts a vector this cycle.
REQ-007 SHALL have port in_data  input  N*8  signed int8 vector; lane i is bits [8i+7:8i].
REQ-008 SHALL have port in_last  input  1  last vector of the tile; sampled on accept.
REQ-009 SHALL have port out_data  output  N*8  skewed int8 lanes driven to the array west edge.
REQ-010 SHALL have port out_valid  output  1  one-cycle strobe: out_data advanced.
REQ-011 SHALL have port out_last  output  1  qualifies out_valid on the final drain step of a tile.
REQ-012 SHALL have port tile_count  output  16  count of completed tiles.

Function
REQ-013 SHALL use an FSM with states IDLE, STREAM and FLUSH.
REQ-014 SHALL drive in_ready = array_en and (state != FLUSH), combinationally.
REQ-015 SHALL accept a vector when in_valid and in_ready are both high.
REQ-016 SHALL advance when a vector is accepted, or when state is FLUSH and array_en is high; no other cycle advances.
REQ-017 SHALL hold every lane register and out_data when not advancing; bubbles insert no zeros.
REQ-018 SHALL delay lane i by i+1 advances, so out_data lane i shows in_data lane i of the vector accepted i advances earlier.
REQ-019 SHALL shift zeros into all lanes on FLUSH advances.
REQ-020 SHALL register out_valid high for exactly one cycle after each advance.
REQ-021 SHALL transition IDLE->STREAM on accept with in_last=0.
REQ-022 SHALL transition IDLE or STREAM->FLUSH on accept with in_last=1; a 1-vector tile is legal.
REQ-023 SHALL remain in FLUSH for exactly N-1 advances, counted by a down-counter, then go to IDLE.
REQ-024 SHALL assert out_last with the out_valid that follows the (N-1)th FLUSH advance; a tile of K vectors produces exactly K+N-1 out_valid strobes.
REQ-025 SHALL allow a new tile to be accepted in the cycle after FLUSH->IDLE, with no extra gap.
REQ-026 SHALL ignore in_valid, in_data and in_last whenever in_ready is low.
REQ-027 SHALL increment tile_count, wrapping 0xFFFF->0, on the cycle out_last is asserted.

Reset
REQ-028 SHALL on reset clear the state to IDLE, and clear all lane registers, out_data, out_valid, out_last, the FLUSH counter and tile_count to 0.
REQ-029 SHALL discard any partial tile when reset is asserted mid-tile, with no out_last and no count increment.

Configuration
REQ-030 SHALL compile the tile counter only when SYSTOLIC_SKEW_FEEDER_TILE_CNT_EN is defined.
REQ-031 SHALL tie tile_count to 0 and omit its register when SYSTOLIC_SKEW_FEEDER_TILE_CNT_EN is undefined; all other behaviour is unchanged.

Structure
REQ-032 SHALL import from shared package systolic_pkg the int8 typedef, the feeder FSM state enum and the lane width constant (8).
REQ-033 SHALL instantiate sub-module skew_delay_line once per lane; each instance has a DEPTH parameter, an advance enable and an async reset.

Verification (N=4)
REQ-034 SHALL test that lane 0 = 1, 2, 3 and lane 3 = 10, 20, 30 (3 vectors, last on third, array_en=1 throughout) produce 6 strobes; lane 0 shows 1, 2, 3, 0, 0, 0; lane 3 shows 0, 0, 0, 10, 20, 30; out_last is on strobe 6.
REQ-035 SHALL test that a single vector of all lanes = -128 with in_last=1 enters FLUSH directly and produces 4 strobes, out_last on strobe 4, then tile_count=1.
REQ-036 SHALL test that in_valid low for 2 cycles mid-STREAM produces no out_valid and leaves out_data unchanged in those cycles; lane alignment is preserved after resume.
REQ-037 SHALL test that array_en low for 3 cycles in FLUSH holds in_ready=0 and the counter; drain completes after re-enable with the correct out_last.
REQ-038 SHALL test that reset asserted after the second vector clears out_data to 0 and the state to IDLE, gives no out_last, and leaves tile_count unchanged at 0.
REQ-039 SHALL test that two back-to-back 2-vector tiles accept tile 2 in the cycle after out_last drain; with SYSTOLIC_SKEW_FEEDER_TILE_CNT_EN, tile_count=2; without it, tile_count=0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types for the systolic feeder: int8 lane type, lane width,
// feeder FSM state encoding and a small lane-slicing helper.
package systolic_pkg;

  localparam int LANE_W = 8;

  typedef logic signed [LANE_W-1:0] int8_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH
  } feed_state_t;

  // Counter width able to hold N-1 for the legal range 2..16.
  function automatic int flush_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One lane of the west-edge skew: a DEPTH-stage int8 shift register
// that moves only on adv. Ports: clk, reset (async, high), adv, din, dout.
module skew_delay_line
  import systolic_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  input  logic [LANE_W-1:0] din,
  output logic [LANE_W-1:0] dout
);

  int8_t sr [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr[i] <= '0;
      end
    end else if (adv) begin
      sr[0] <= int8_t'(din);
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews N int8 lanes onto the array west edge; lane i lags i+1 advances,
// then N-1 zero advances drain each tile.
// Ports: clk, reset, array_en, in_valid/in_ready/in_data/in_last,
// out_data/out_valid/out_last, tile_count.
// Option: SYSTOLIC_SKEW_FEEDER_TILE_CNT_EN builds the tile counter,
// otherwise tile_count is tied to 0.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                array_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*LANE_W-1:0] in_data,
  input  logic                in_last,
  output logic [N*LANE_W-1:0] out_data,
  output logic                out_valid,
  output logic                out_last,
  output logic [15:0]         tile_count
);

  localparam int CW = flush_cnt_w(N);
  localparam logic [CW-1:0] FLUSH_LEN = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  feed_state_t   state;
  logic [CW-1:0] flush_cnt;

  logic accept;
  logic flush_adv;
  logic adv;
  logic drain_done;
  logic [N*LANE_W-1:0] lane_in;

  assign in_ready   = array_en && (state != ST_FLUSH);
  assign accept     = in_valid && in_ready;
  assign flush_adv  = array_en && (state == ST_FLUSH);
  assign adv        = accept || flush_adv;
  assign drain_done = flush_adv && (flush_cnt == CNT_ONE);

  // Flush advances push zeros; accepts push the vector.
  assign lane_in = accept ? in_data : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH(i + 1)
    ) u_dl (
      .clk  (clk),
      .reset(reset),
      .adv  (adv),
      .din  (lane_in[i*LANE_W +: LANE_W]),
      .dout (out_data[i*LANE_W +: LANE_W])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= adv;
      out_last  <= drain_done;
      unique case (state)
        ST_IDLE, ST_STREAM: begin
          if (accept) begin
            if (in_last) begin
              state     <= ST_FLUSH;
              flush_cnt <= FLUSH_LEN;
            end else begin
              state <= ST_STREAM;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_adv) begin
            flush_cnt <= flush_cnt - CNT_ONE;
            if (flush_cnt == CNT_ONE) begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          flush_cnt <= '0;
        end
      endcase
    end
  end

`ifdef SYSTOLIC_SKEW_FEEDER_TILE_CNT_EN
  // Bumps on the same edge that raises out_last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_count <= '0;
    end else if (drain_done) begin
      tile_count <= tile_count + 16'd1;
    end
  end
`else
  assign tile_count = '0;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed + random bench for systolic_skew_feeder (N=4) against a
// history-queue model of the skewed west-edge stream.
module tb_systolic_skew_feeder;

  localparam int N = 4;
  localparam int W = N * 8;

  logic         clk;
  logic         reset;
  logic         array_en;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic [15:0]  tile_count;

  systolic_skew_feeder #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .array_en  (array_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .tile_count(tile_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: every advance pushes one vector (accepted data or zeros);
  // lane i shows the vector pushed i advances before the newest one.
  logic [W-1:0] hist[$];
  int           m_left = 0;
  int           m_tiles = 0;
  int           strobes = 0;
  int           last_at = 0;
  logic [W-1:0] strobe_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [W-1:0] exp_od();
    logic [W-1:0] r;
    logic [W-1:0] t;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (hist.size() > i) begin
        t = hist[hist.size() - 1 - i];
        r[8*i +: 8] = t[8*i +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_tc();
`ifdef SYSTOLIC_SKEW_FEEDER_TILE_CNT_EN
    return 16'(m_tiles);
`else
    return 16'd0;
`endif
  endfunction

  task automatic drv(input logic v, input logic [W-1:0] d,
                     input logic l, input logic en);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    array_en = en;
  endtask

  task automatic cycle();
    logic rdy, acc, adv, lst;
    logic [W-1:0] pv;
    #1;
    rdy = array_en && (m_left == 0);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    acc = in_valid && rdy;
    adv = acc || (m_left > 0 && array_en);
    lst = 1'b0;
    pv  = acc ? in_data : '0;
    if (acc && in_last) begin
      m_left = N - 1;
    end else if (!acc && adv) begin
      m_left--;
      if (m_left == 0) begin
        lst = 1'b1;
        m_tiles++;
      end
    end
    @(posedge clk);
    #1;
    if (adv) begin
      hist.push_back(pv);
      if (hist.size() > N) void'(hist.pop_front());
    end
    chk("out_valid", 32'(out_valid), 32'(adv));
    chk("out_last", 32'(out_last), 32'(lst));
    chk("out_data", out_data, exp_od());
    chk("tile_count", 32'(tile_count), 32'(exp_tc()));
    if (out_valid) begin
      strobes++;
      strobe_q.push_back(out_data);
      if (out_last) last_at = strobes;
    end
  endtask

  task automatic do_reset();
    drv(1'b0, '0, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_last", 32'(out_last), 32'h0);
    chk("rst_tile_count", 32'(tile_count), 32'h0);
    hist.delete();
    m_left = 0;
    m_tiles = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    strobes = 0;
    last_at = 0;
    strobe_q.delete();
  endtask

  logic [7:0]   exp_l0 [6];
  logic [7:0]   exp_l3 [6];
  logic [W-1:0] held;
  logic [W-1:0] t;

  initial begin
    reset = 1'b1;
    drv(1'b0, '0, 1'b0, 1'b0);
    #2;
    do_reset();
    chk("idle_in_ready", 32'(in_ready), 32'h1);

    // Three-vector tile with explicit lane sequences.
    drv(1'b1, mk(8'd1, 8'd0, 8'd0, 8'd10), 1'b0, 1'b1);
    cycle();
    drv(1'b1, mk(8'd2, 8'd0, 8'd0, 8'd20), 1'b0, 1'b1);
    cycle();
    drv(1'b1, mk(8'd3, 8'd0, 8'd0, 8'd30), 1'b1, 1'b1);
    cycle();
    drv(1'b0, '0, 1'b0, 1'b1);
    repeat (4) cycle();
    exp_l0 = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0};
    exp_l3 = '{8'd0, 8'd0, 8'd0, 8'd10, 8'd20, 8'd30};
    chk("t3_strobes", 32'(strobes), 32'd6);
    chk("t3_last_at", 32'(last_at), 32'd6);
    for (int i = 0; i < 6 && i < strobe_q.size(); i++) begin
      t = strobe_q[i];
      chk("t3_lane0", 32'(t[7:0]), 32'(exp_l0[i]));
      chk("t3_lane3", 32'(t[31:24]), 32'(exp_l3[i]));
    end

    // Single-vector tile of -128.
    do_reset();
    drv(1'b1, {N{8'h80}}, 1'b1, 1'b1);
    cycle();
    drv(1'b0, '0, 1'b0, 1'b1);
    repeat (4) cycle();
    chk("t1_strobes", 32'(strobes), 32'd4);
    chk("t1_last_at", 32'(last_at), 32'd4);
`ifdef SYSTOLIC_SKEW_FEEDER_TILE_CNT_EN
    chk("t1_tile_count", 32'(tile_count), 32'd1);
`else
    chk("t1_tile_count", 32'(tile_count), 32'd0);
`endif

    // Bubbles mid-stream.
    drv(1'b1, mk(8'h11, 8'h21, 8'h31, 8'h41), 1'b0, 1'b1);
    cycle();
    drv(1'b1, mk(8'h12, 8'h22, 8'h32, 8'h42), 1'b0, 1'b1);
    cycle();
    held = out_data;
    drv(1'b0, mk(8'hee, 8'hee, 8'hee, 8'hee), 1'b1, 1'b1);
    repeat (2) begin
      cycle();
      chk("bub_hold", out_data, held);
      chk("bub_valid", 32'(out_valid), 32'h0);
    end
    drv(1'b1, mk(8'h13, 8'h23, 8'h33, 8'h43), 1'b0, 1'b1);
    cycle();
    drv(1'b1, mk(8'h14, 8'h24, 8'h34, 8'h44), 1'b1, 1'b1);
    cycle();
    drv(1'b0, '0, 1'b0, 1'b1);
    repeat (4) cycle();

    // array_en freeze during FLUSH.
    strobes = 0;
    last_at = 0;
    drv(1'b1, mk(8'h51, 8'h52, 8'h53, 8'h54), 1'b0, 1'b1);
    cycle();
    drv(1'b1, mk(8'h61, 8'h62, 8'h63, 8'h64), 1'b1, 1'b1);
    cycle();
    drv(1'b0, '0, 1'b0, 1'b1);
    cycle();
    held = out_data;
    drv(1'b1, mk(8'h77, 8'h77, 8'h77, 8'h77), 1'b0, 1'b0);
    repeat (3) begin
      cycle();
      chk("frz_ready", 32'(in_ready), 32'h0);
      chk("frz_hold", out_data, held);
    end
    drv(1'b1, mk(8'h77, 8'h77, 8'h77, 8'h77), 1'b0, 1'b1);
    repeat (2) cycle();
    chk("frz_strobes", 32'(strobes), 32'd5);
    chk("frz_last_at", 32'(last_at), 32'd5);
    drv(1'b0, '0, 1'b0, 1'b1);
    cycle();

    // Reset mid-tile.
    do_reset();
    drv(1'b1, mk(8'h01, 8'h02, 8'h03, 8'h04), 1'b0, 1'b1);
    cycle();
    drv(1'b1, mk(8'h05, 8'h06, 8'h07, 8'h08), 1'b0, 1'b1);
    cycle();
    do_reset();
    repeat (4) cycle();
    chk("mid_rst_tc", 32'(tile_count), 32'd0);
    chk("mid_rst_lastcnt", 32'(last_at), 32'd0);

    // Back-to-back two-vector tiles.
    do_reset();
    drv(1'b1, mk(8'ha1, 8'ha2, 8'ha3, 8'ha4), 1'b0, 1'b1);
    cycle();
    drv(1'b1, mk(8'hb1, 8'hb2, 8'hb3, 8'hb4), 1'b1, 1'b1);
    cycle();
    drv(1'b1, mk(8'hc1, 8'hc2, 8'hc3, 8'hc4), 1'b0, 1'b1);
    repeat (3) cycle();
    chk("b2b_ready", 32'(in_ready), 32'h1);
    chk("b2b_last1", 32'(out_last), 32'h1);
    cycle();
    drv(1'b1, mk(8'hd1, 8'hd2, 8'hd3, 8'hd4), 1'b1, 1'b1);
    cycle();
    drv(1'b0, '0, 1'b0, 1'b1);
    repeat (4) cycle();
    chk("b2b_strobes", 32'(strobes), 32'd10);
`ifdef SYSTOLIC_SKEW_FEEDER_TILE_CNT_EN
    chk("b2b_tile_count", 32'(tile_count), 32'd2);
`else
    chk("b2b_tile_count", 32'(tile_count), 32'd0);
`endif

    // Random traffic.
    repeat (400) begin
      drv(1'($urandom_range(0, 9) < 6), W'($urandom),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
      cycle();
    end
    drv(1'b0, '0, 1'b0, 1'b1);
    repeat (N + 1) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
